// File: rtl/camera_pkg.sv
// Shared FSM definitions for the camera frame sequencer.
package camera_pkg;

    localparam int unsigned CAM_STATE_W = 3;

    typedef enum logic [CAM_STATE_W-1:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        WAIT_SOF = 3'd2,
        CAPTURE  = 3'd3,
        FINISH   = 3'd4
    } cam_state_e;

endpackage

// File: rtl/camera_frame_seq.sv
// Ping-pong camera frame sequencer: arms the uDMA rx channel per frame,
// tracks SOF/EOF, counts completed frames and flags short or lost frames.
module camera_frame_seq
    import camera_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [7:0]                num_frames_i,
    input  logic [L2_AWIDTH_NOAL-1:0] buf0_addr_i,
    input  logic [L2_AWIDTH_NOAL-1:0] buf1_addr_i,
    input  logic [TRANS_SIZE-1:0]     frame_size_i,
    input  logic                      sof_i,
    input  logic                      eof_i,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic                      cfg_rx_en_o,
    output logic                      cfg_rx_clr_o,
    input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    output logic                      cam_en_o,
    output logic                      busy_o,
    output logic                      buf_idx_o,
    output logic [7:0]                frame_cnt_o,
    output logic                      frame_done_o,
    output logic                      short_frame_o,
    output logic                      overflow_o
);

    cam_state_e                r_state;
    cam_state_e                w_state_d;
    logic                      r_buf_idx;
    logic                      w_buf_idx_d;
    logic [7:0]                r_frame_cnt;
    logic [7:0]                w_frame_cnt_d;
    logic [7:0]                r_num_frames;
    logic [7:0]                w_num_frames_d;
    logic                      r_active;
    logic                      r_rx_en;
    logic                      r_rx_clr;
    logic                      r_frame_done;
    logic                      r_short;
    logic                      r_ovf;
    logic [L2_AWIDTH_NOAL-1:0] r_addr;
    logic [TRANS_SIZE-1:0]     r_size;
    logic                      w_done;
    logic                      w_short;
    logic                      w_clr;
    logic                      w_ovf;

    // Pulses are computed on the transition and registered, so they appear
    // during the cycle spent in the destination state.
    always_comb begin
        w_state_d      = r_state;
        w_buf_idx_d    = r_buf_idx;
        w_frame_cnt_d  = r_frame_cnt;
        w_num_frames_d = r_num_frames;
        w_done         = 1'b0;
        w_short        = 1'b0;
        w_clr          = 1'b0;
        w_ovf          = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_d      = ARM;
                    w_buf_idx_d    = 1'b0;
                    w_frame_cnt_d  = 8'd0;
                    w_num_frames_d = num_frames_i;
                end
            end
            ARM: w_state_d = WAIT_SOF;
            WAIT_SOF: begin
                if (sof_i) begin
                    w_state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (eof_i) begin
                    w_state_d     = FINISH;
                    w_done        = 1'b1;
                    w_frame_cnt_d = r_frame_cnt + 8'd1;
                    w_buf_idx_d   = ~r_buf_idx;
                    w_ovf         = sof_i;
                    if (cfg_rx_bytes_left_i != '0) begin
                        w_short = 1'b1;
                        w_clr   = 1'b1;
                    end
                end else if (sof_i) begin
                    w_state_d = ARM;
                    w_ovf     = 1'b1;
                    w_clr     = 1'b1;
                end
            end
            FINISH: begin
                if (r_num_frames != 8'd0 && r_num_frames == r_frame_cnt) begin
                    w_state_d = IDLE;
                end else begin
                    w_state_d = ARM;
                end
            end
            default: w_state_d = IDLE;
        endcase

        if (r_state != IDLE && stop_i) begin
            w_state_d     = IDLE;
            w_buf_idx_d   = r_buf_idx;
            w_frame_cnt_d = r_frame_cnt;
            w_done        = 1'b0;
            w_short       = 1'b0;
            w_ovf         = 1'b0;
            w_clr         = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            r_buf_idx    <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_num_frames <= 8'd0;
            r_active     <= 1'b0;
            r_rx_en      <= 1'b0;
            r_rx_clr     <= 1'b0;
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
            r_ovf        <= 1'b0;
            r_addr       <= '0;
            r_size       <= '0;
        end else begin
            r_state      <= w_state_d;
            r_buf_idx    <= w_buf_idx_d;
            r_frame_cnt  <= w_frame_cnt_d;
            r_num_frames <= w_num_frames_d;
            r_active     <= (w_state_d != IDLE);
            r_rx_en      <= (w_state_d == ARM);
            r_rx_clr     <= w_clr;
            r_frame_done <= w_done;
            r_short      <= w_short;
            r_ovf        <= w_ovf;
            // ARM never repeats back-to-back, so this loads exactly on entry.
            if (w_state_d == ARM) begin
                r_addr <= w_buf_idx_d ? buf1_addr_i : buf0_addr_i;
                r_size <= frame_size_i;
            end
        end
    end

    assign cfg_rx_startaddr_o = r_addr;
    assign cfg_rx_size_o      = r_size;
    assign cfg_rx_en_o        = r_rx_en;
    assign cfg_rx_clr_o       = r_rx_clr;
    assign cam_en_o           = r_active;
    assign busy_o             = r_active;
    assign buf_idx_o          = r_buf_idx;
    assign frame_cnt_o        = r_frame_cnt;
    assign frame_done_o       = r_frame_done;
    assign short_frame_o      = r_short;
    assign overflow_o         = r_ovf;

endmodule

// File: doc/camera_frame_seq.md
CAMERA_FRAME_SEQ -- requirements
Module: camera_frame_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk_i and rstn_i.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- L2_AWIDTH_NOAL, 12, L2 address width.
- TRANS_SIZE, 16, transfer size width.

REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  system clock.
- rstn_i  in  1  async active-low reset.
- start_i  in  1  pulse; begin capture sequence.
- stop_i  in  1  pulse; abort sequence.
- num_frames_i  in  8  frames to capture; 0 = continuous; sampled on accepted start_i.
- buf0_addr_i  in  L2_AWIDTH_NOAL  ping buffer start address.
- buf1_addr_i  in  L2_AWIDTH_NOAL  pong buffer start address.
- frame_size_i  in  TRANS_SIZE  bytes per buffer.
- sof_i  in  1  start-of-frame pulse, already in clk_i domain.
- eof_i  in  1  end-of-frame pulse, already in clk_i domain.
- cfg_rx_startaddr_o  out  L2_AWIDTH_NOAL  uDMA rx start address.
- cfg_rx_size_o  out  TRANS_SIZE  uDMA rx size.
- cfg_rx_en_o  out  1  one-cycle channel enable pulse.
- cfg_rx_clr_o  out  1  one-cycle channel clear pulse.
- cfg_rx_bytes_left_i  in  TRANS_SIZE  uDMA remaining bytes.
- cam_en_o  out  1  level; camera interface enable.
- busy_o  out  1  high when state != IDLE.
- buf_idx_o  out  1  buffer currently armed (0 = buf0, 1 = buf1).
- frame_cnt_o  out  8  completed frames, wraps 255->0.
- frame_done_o  out  1  pulse; frame completed.
- short_frame_o  out  1  pulse with frame_done_o when bytes_left != 0 at eof.
- overflow_o  out  1  pulse; frame lost.

Function
REQ-004 The FSM SHALL have the states IDLE, ARM, WAIT_SOF, CAPTURE and FINISH.
REQ-005 In IDLE, an accepted start_i SHALL:
- go to ARM next cycle;
- clear frame_cnt_o and buf_idx_o;
- latch num_frames_i.

REQ-006 On entry to ARM, the block SHALL register cfg_rx_startaddr_o (buf0_addr_i or buf1_addr_i per buf_idx_o) and cfg_rx_size_o = frame_size_i; both SHALL hold stable until the next ARM entry.
REQ-007 ARM SHALL last exactly one cycle, during which cfg_rx_en_o = 1; the next state SHALL be WAIT_SOF.
REQ-008 cam_en_o SHALL be 1 in every state except IDLE.
REQ-009 In WAIT_SOF, sof_i SHALL move the FSM to CAPTURE; eof_i in WAIT_SOF SHALL be ignored.
REQ-010 In CAPTURE, eof_i SHALL move the FSM to FINISH.
REQ-011 In CAPTURE, sof_i without eof_i SHALL:
- pulse overflow_o and cfg_rx_clr_o;
- go to ARM with the same buf_idx_o;
- leave frame_cnt_o unchanged.

REQ-012 In CAPTURE, simultaneous eof_i and sof_i SHALL be treated as eof (go to FINISH) and SHALL pulse overflow_o.
REQ-013 FINISH SHALL last one cycle, during which:
- frame_done_o = 1;
- frame_cnt_o increments;
- buf_idx_o toggles;
- if cfg_rx_bytes_left_i != 0, short_frame_o and cfg_rx_clr_o pulse.

REQ-014 After FINISH, the FSM SHALL go to IDLE if the latched count is nonzero and equals the new frame_cnt_o; otherwise it SHALL go to ARM.
REQ-015 stop_i in any non-IDLE state SHALL:
- pulse cfg_rx_clr_o;
- go to IDLE next cycle;
- suppress frame_done_o.

REQ-016 stop_i SHALL take priority over start_i, sof_i and eof_i in the same cycle; start_i outside IDLE SHALL be ignored.
REQ-017 All outputs SHALL be registered; pulses SHALL be exactly one cycle wide.

Reset
REQ-018 On rstn_i low, the block SHALL asynchronously set:
- state = IDLE;
- all pulse outputs, cam_en_o, busy_o, buf_idx_o and frame_cnt_o = 0;
- cfg_rx_startaddr_o and cfg_rx_size_o = 0.

REQ-019 Reset mid-capture SHALL drop state without issuing cfg_rx_clr_o; the uDMA channel is reset by the same rstn_i.

Structure
REQ-020 The state enum and state width SHALL live in shared package camera_pkg; the module SHALL contain no sub-modules.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- num_frames=2, buf0=0x100, buf1=0x200, size=0x40, full frames with bytes_left=0 at eof -> cfg_rx_en_o pulses with addr 0x100 then 0x200; two frame_done_o; frame_cnt_o=2; back to IDLE with cam_en_o=0.
- num_frames=0, five frames -> five frame_done_o, addresses alternate 0x100/0x200, busy_o stays 1; stop_i then returns to IDLE with one cfg_rx_clr_o.
- eof_i with bytes_left=0x10 -> frame_done_o, short_frame_o and cfg_rx_clr_o in the same cycle.
- second sof_i in CAPTURE before eof -> overflow_o and cfg_rx_clr_o; re-arm at the same address; frame_cnt_o unchanged.
- stop_i coincident with eof_i -> no frame_done_o; IDLE next cycle.
- rstn_i asserted in CAPTURE -> all outputs 0 immediately; a following start_i arms buf0.
